lcd_ctrl: RTL and testbench

- Consumer end of the LSU LCD register. Takes the 32-bit LCD register the LSU drives (`o_io_lcd`) and turns each software command into a correctly timed HD44780-style write cycle on the LCD pins: setup, EN pulse, hold, then an execution wait.
- Returns a status word that the LSU maps as a read-only load source, so software can poll the busy bit.

---
 rtl/lcd_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD write controller fed by the LSU LCD register; returns a pollable status word.
// Optional power-on init sequencer is enabled with `define LCD_POWERON_INIT_EN.
module lcd_ctrl #(
    parameter int T_SETUP_CYC = 4,
    parameter int T_EN_CYC    = 16,
    parameter int T_HOLD_CYC  = 4,
    parameter int T_EXEC_CYC  = 2000,
    parameter int T_LONG_CYC  = 82000,
    parameter int CNT_W       = $clog2(T_LONG_CYC + 1)
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [31:0] i_lcd_reg,
    output logic [31:0] o_lcd_status,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_lcd_blon
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } state_t;

    // Counter reload values: each phase lasts exactly its T_*_CYC cycles (load N-1, leave at 0).
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(T_EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(T_EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(T_LONG_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             long_q, long_d;
    logic             en_q;
    logic             dropped_q, dropped_d;
    logic             go_q, clr_q;

    logic             go_rise, clr_rise, sw_accept;
    logic             init_done, init_issue;
    logic [7:0]       init_cmd;
    logic             busy;
    logic             unused_bits;

    assign go_rise     = i_lcd_reg[10] & ~go_q;
    assign clr_rise    = i_lcd_reg[11] & ~clr_q;
    assign sw_accept   = go_rise && (state_q == IDLE) && init_done && !init_issue;
    assign unused_bits = ^{i_lcd_reg[29:12], i_lcd_reg[9]};

`ifdef LCD_POWERON_INIT_EN
    localparam int PWR_WAIT_CYC = 750000;
    localparam int PWR_W        = $clog2(PWR_WAIT_CYC + 1);

    logic [PWR_W-1:0] pwr_cnt;
    logic [2:0]       init_idx;
    logic             init_done_q;

    always_comb begin
        case (init_idx)
            3'd0, 3'd1, 3'd2: init_cmd = 8'h38;
            3'd3:             init_cmd = 8'h0C;
            3'd4:             init_cmd = 8'h01;
            default:          init_cmd = 8'h06;
        endcase
    end

    assign init_done  = init_done_q;
    assign init_issue = !init_done_q && (pwr_cnt == '0) && (state_q == IDLE) && (init_idx != 3'd6);

    // Power-on wait, then one internal command per IDLE visit; done once the last one retires.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pwr_cnt     <= PWR_W'(PWR_WAIT_CYC - 1);
            init_idx    <= 3'd0;
            init_done_q <= 1'b0;
        end else if (!init_done_q) begin
            if (pwr_cnt != '0) begin
                pwr_cnt <= pwr_cnt - 1'b1;
            end else if (state_q == IDLE) begin
                if (init_idx == 3'd6) begin
                    init_done_q <= 1'b1;
                end else begin
                    init_idx <= init_idx + 3'd1;
                end
            end
        end
    end
`else
    assign init_done  = 1'b1;
    assign init_issue = 1'b0;
    assign init_cmd   = 8'h00;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        rs_d      = rs_q;
        long_d    = long_q;
        dropped_d = dropped_q;

        case (state_q)
            IDLE: begin
                if (init_issue) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                    data_d  = init_cmd;
                    rs_d    = 1'b0;
                    long_d  = (init_cmd == 8'h01);
                end else if (sw_accept) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                    data_d  = i_lcd_reg[7:0];
                    rs_d    = i_lcd_reg[8];
                    // Clear display / return home (0x01..0x03) need the long execution time.
                    long_d  = !i_lcd_reg[8] && (i_lcd_reg[7:0] != 8'h00) && (i_lcd_reg[7:2] == 6'd0);
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = EN_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = WAIT;
                    cnt_d   = long_q ? LONG_LD : EXEC_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_rise && !sw_accept) begin
            dropped_d = 1'b1;
        end else if (clr_rise) begin
            dropped_d = 1'b0;
        end
    end

    // EN is registered from the next state so it is a clean, glitch-free strobe.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= 8'h00;
            rs_q      <= 1'b0;
            long_q    <= 1'b0;
            en_q      <= 1'b0;
            dropped_q <= 1'b0;
            go_q      <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            rs_q      <= rs_d;
            long_q    <= long_d;
            en_q      <= (state_d == PULSE);
            dropped_q <= dropped_d;
            go_q      <= i_lcd_reg[10];
            clr_q     <= i_lcd_reg[11];
        end
    end

    assign busy         = (state_q != IDLE) || !init_done;
    assign o_lcd_status = {29'd0, init_done, dropped_q, busy};
    assign o_lcd_data   = data_q;
    assign o_lcd_rs     = rs_q;
    assign o_lcd_rw     = 1'b0;
    assign o_lcd_en     = en_q;
    assign o_lcd_on     = i_lcd_reg[31];
    assign o_lcd_blon   = i_lcd_reg[30];

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: stimulus queues expected write cycles, a monitor checks each one as busy falls.
module tb_lcd_ctrl;

    localparam int T_SETUP    = 4;
    localparam int T_EN       = 16;
    localparam int T_HOLD     = 4;
    localparam int T_EXEC     = 200;
    localparam int T_LONG     = 1200;
    localparam int BUSY_SHORT = T_SETUP + T_EN + T_HOLD + T_EXEC;
    localparam int BUSY_LONG  = T_SETUP + T_EN + T_HOLD + T_LONG;

    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         busy_len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] lcd_reg = 32'h0;
    logic [31:0] lcd_status;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_SETUP_CYC(T_SETUP),
        .T_EN_CYC   (T_EN),
        .T_HOLD_CYC (T_HOLD),
        .T_EXEC_CYC (T_EXEC),
        .T_LONG_CYC (T_LONG)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rst_n),
        .i_lcd_reg   (lcd_reg),
        .o_lcd_status(lcd_status),
        .o_lcd_data  (lcd_data),
        .o_lcd_rs    (lcd_rs),
        .o_lcd_rw    (lcd_rw),
        .o_lcd_en    (lcd_en),
        .o_lcd_on    (lcd_on),
        .o_lcd_blon  (lcd_blon)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic issue_cmd(input logic [7:0] d, input logic rs, input int busy_len, input bit track);
        exp_t e;
        if (track) begin
            e.data     = d;
            e.rs       = rs;
            e.busy_len = busy_len;
            exp_q.push_back(e);
        end
        lcd_reg       = 32'h0;
        lcd_reg[7:0]  = d;
        lcd_reg[8]    = rs;
        lcd_reg[10]   = 1'b1;
        @(negedge clk);
        lcd_reg[10]   = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (lcd_status[0] && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (lcd_status[0]) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL wait_idle: busy=1 after %0d cycles, required 0", limit);
        end
    endtask

    // Monitor: measures each write cycle and compares it against the oldest queued expectation.
    initial begin : monitor
        int         busy_cnt, en_cnt, setup_cnt;
        logic       prev_busy, stable_ok, cap_rs;
        logic [7:0] cap_data;
        exp_t       e;
        busy_cnt = 0; en_cnt = 0; setup_cnt = 0;
        prev_busy = 1'b0; stable_ok = 1'b1; cap_rs = 1'b0; cap_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0; en_cnt = 0; setup_cnt = 0;
                prev_busy = 1'b0; stable_ok = 1'b1;
            end else begin
                if (lcd_status[0]) begin
                    busy_cnt++;
                    if (lcd_en) begin
                        en_cnt++;
                        if (en_cnt == 1) begin
                            cap_data = lcd_data;
                            cap_rs   = lcd_rs;
                        end else if (lcd_data !== cap_data || lcd_rs !== cap_rs) begin
                            stable_ok = 1'b0;
                        end
                    end else if (en_cnt == 0) begin
                        setup_cnt++;
                    end
                end else if (prev_busy) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("[TB] FAIL unexpected_cmd: got write of 0x%02h, required none", cap_data);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("cmd_data",     cap_data,  e.data);
                        check_output("cmd_rs",       cap_rs,    e.rs);
                        check_output("setup_cycles", setup_cnt, T_SETUP);
                        check_output("en_cycles",    en_cnt,    T_EN);
                        check_output("busy_cycles",  busy_cnt,  e.busy_len);
                        check_output("data_stable",  stable_ok, 1'b1);
                        check_output("data_retained", lcd_data, e.data);
                    end
                    busy_cnt = 0; en_cnt = 0; setup_cnt = 0; stable_ok = 1'b1;
                end
                prev_busy = lcd_status[0];
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        // Reset values.
        #1;
        check_output("rst_status", lcd_status, 32'h4);
        check_output("rst_data",   lcd_data,   8'h00);
        check_output("rst_rs",     lcd_rs,     1'b0);
        check_output("rst_en",     lcd_en,     1'b0);
        check_output("rst_rw",     lcd_rw,     1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Power and backlight pass straight through.
        lcd_reg = 32'hC000_0000;
        #1;
        check_output("on_hi",   lcd_on,   1'b1);
        check_output("blon_hi", lcd_blon, 1'b1);
        lcd_reg = 32'h4000_0000;
        #1;
        check_output("on_lo",   lcd_on,   1'b0);
        check_output("blon_hi2", lcd_blon, 1'b1);
        lcd_reg = 32'h0;
        @(negedge clk);

        // Instruction write 0x41, short wait.
        issue_cmd(8'h41, 1'b0, BUSY_SHORT, 1'b1);
        check_output("busy_after_go", lcd_status, 32'h5);
        wait_idle(5000);
        check_output("status_idle1", lcd_status, 32'h4);

        // Data write (RS=1).
        issue_cmd(8'h41, 1'b1, BUSY_SHORT, 1'b1);
        wait_idle(5000);
        check_output("status_idle2", lcd_status, 32'h4);

        // Clear display takes the long wait.
        issue_cmd(8'h01, 1'b0, BUSY_LONG, 1'b1);
        wait_idle(5000);

        // GO during WAIT is dropped; outputs keep the in-flight command.
        issue_cmd(8'h41, 1'b1, BUSY_SHORT, 1'b1);
        repeat (30) @(negedge clk);
        lcd_reg = 32'h0000_0455;
        @(negedge clk);
        check_output("drop_status", lcd_status, 32'h7);
        check_output("drop_data",   lcd_data,   8'h41);
        lcd_reg = 32'h0000_0055;
        wait_idle(5000);
        check_output("drop_sticky", lcd_status, 32'h6);
        lcd_reg = 32'h0000_0800;
        @(negedge clk);
        check_output("drop_cleared", lcd_status, 32'h4);
        lcd_reg = 32'h0;
        @(negedge clk);

        // Trigger in the final WAIT cycle is dropped.
        issue_cmd(8'h41, 1'b0, BUSY_SHORT, 1'b1);
        repeat (BUSY_SHORT - 1) @(negedge clk);
        lcd_reg = 32'h0000_0499;
        @(negedge clk);
        check_output("last_wait_drop", lcd_status, 32'h6);
        check_output("last_wait_data", lcd_data,   8'h41);
        lcd_reg = 32'h0000_0800;
        @(negedge clk);
        check_output("clr_after_last", lcd_status, 32'h4);
        lcd_reg = 32'h0;
        @(negedge clk);

        // Trigger in the first IDLE cycle after completion is accepted.
        issue_cmd(8'h0C, 1'b0, BUSY_SHORT, 1'b1);
        repeat (BUSY_SHORT) @(negedge clk);
        issue_cmd(8'h38, 1'b1, BUSY_SHORT, 1'b1);
        check_output("first_idle_accept", lcd_status, 32'h5);
        wait_idle(5000);

        // Reset during PULSE abandons the command at once.
        issue_cmd(8'h5A, 1'b1, BUSY_SHORT, 1'b0);
        repeat (8) @(negedge clk);
        check_output("pulse_en", lcd_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_en",     lcd_en,     1'b0);
        check_output("arst_data",   lcd_data,   8'h00);
        check_output("arst_status", lcd_status, 32'h4);
        repeat (2) @(negedge clk);
        lcd_reg = 32'h0;
        rst_n   = 1'b1;
        repeat (5) @(negedge clk);
        check_output("post_rst_idle", lcd_status, 32'h4);
        check_output("post_rst_en",   lcd_en,     1'b0);

        repeat (5) @(negedge clk);
        check_output("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
